// File: rtl/i2s_pkg.sv
// i2s_pkg: shared frame geometry, bit-index type and slot helpers for the I2S transmitter.
package i2s_pkg;

  localparam int unsigned SLOT_BITS  = 32;
  localparam int unsigned FRAME_BITS = 64;
  localparam int unsigned BIT_IDX_W  = 6;
  localparam int unsigned SLOT_IDX_W = BIT_IDX_W - 1;

  typedef logic [BIT_IDX_W-1:0]  bit_idx_t;
  typedef logic [SLOT_IDX_W-1:0] slot_idx_t;

  localparam bit_idx_t IDX_LAST      = bit_idx_t'(FRAME_BITS - 1);
  localparam bit_idx_t LRCK_HI_FIRST = bit_idx_t'(SLOT_BITS - 1);
  localparam bit_idx_t LRCK_HI_LAST  = bit_idx_t'(FRAME_BITS - 2);

  // Word select leads each slot by one bit: high from the last left bit up to the last right bit.
  function automatic logic lrck_level(input bit_idx_t idx);
    return (idx >= LRCK_HI_FIRST) && (idx <= LRCK_HI_LAST);
  endfunction

  // MSB-first bit k of a left-aligned slot word.
  function automatic logic slot_bit(input logic [SLOT_BITS-1:0] word, input slot_idx_t k);
    return word[slot_idx_t'(SLOT_BITS - 1) - k];
  endfunction

endpackage

// File: rtl/i2s_tx_if.sv
// i2s_tx_if: mono sample/valid stream from the effects pipeline into the I2S transmitter.
interface i2s_tx_if #(
  parameter int unsigned fxp_size = 16
) ();

  logic [fxp_size-1:0] i_sample;
  logic                i_valid;

  modport master (output i_sample, output i_valid);
  modport slave  (input  i_sample, input  i_valid);

endinterface

// File: rtl/i2s_bclk_gen.sv
// i2s_bclk_gen: divides clk down to the I2S bit clock and flags the clock in which BCLK falls.
module i2s_bclk_gen #(
  parameter int unsigned bclk_div = 4
) (
  input  logic clk,
  input  logic rst,
  output logic o_bclk,
  output logic o_fall_c
);

  localparam int unsigned     DIV_W    = (bclk_div > 1) ? $clog2(bclk_div) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(bclk_div - 1);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             bclk_q, bclk_d;
  logic             tc_c;

  always_comb begin
    tc_c   = (cnt_q == DIV_LAST);
    cnt_d  = cnt_q + DIV_W'(1);
    bclk_d = bclk_q;
    if (tc_c) begin
      cnt_d  = '0;
      bclk_d = ~bclk_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q  <= '0;
      bclk_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      bclk_q <= bclk_d;
    end
  end

  assign o_bclk   = bclk_q;
  assign o_fall_c = tc_c & bclk_q;

endmodule

// File: rtl/i2s_tx.sv
// i2s_tx: Philips I2S master transmitter, each mono sample sent on both 32-bit slots.
// Optional saturating overrun/underrun counters are enabled by defining I2S_TX_STATUS_CNT_EN.
module i2s_tx
  import i2s_pkg::*;
#(
  parameter int unsigned fxp_size = 16,
  parameter int unsigned bclk_div = 4
) (
  input  logic              clk,
  input  logic              rst,
  i2s_tx_if.slave           in_if,
  output logic              o_bclk,
  output logic              o_lrck,
  output logic              o_sdata,
  output logic              o_overrun,
  output logic              o_underrun
`ifdef I2S_TX_STATUS_CNT_EN
  ,
  output logic [15:0]       o_overrun_cnt,
  output logic [15:0]       o_underrun_cnt
`endif
);

  localparam int unsigned LEFT_SHIFT = SLOT_BITS - fxp_size;

  logic                 fall_c;
  logic                 frame_start_c;
  logic                 consume_c;
  logic [SLOT_BITS-1:0] frame_left_c;

  bit_idx_t             bit_idx_q, bit_idx_d;
  logic [fxp_size-1:0]  hold_q, hold_d;
  logic [fxp_size-1:0]  frame_q, frame_d;
  logic                 hold_v_q, hold_v_d;
  logic                 lrck_q, lrck_d;
  logic                 sdata_q, sdata_d;
  logic                 ovr_q, ovr_d;
  logic                 unr_q, unr_d;

  i2s_bclk_gen #(
    .bclk_div (bclk_div)
  ) u_bclk_gen (
    .clk      (clk),
    .rst      (rst),
    .o_bclk   (o_bclk),
    .o_fall_c (fall_c)
  );

  // Hold/frame hand-off, bit counter and serializer; everything except hold moves only on the fall strobe.
  always_comb begin
    bit_idx_d = bit_idx_q;
    hold_d    = hold_q;
    hold_v_d  = hold_v_q;
    frame_d   = frame_q;
    lrck_d    = lrck_q;
    sdata_d   = sdata_q;
    ovr_d     = 1'b0;
    unr_d     = 1'b0;

    frame_start_c = fall_c && (bit_idx_q == IDX_LAST);
    consume_c     = frame_start_c && hold_v_q;

    if (consume_c) begin
      frame_d  = hold_q;
      hold_v_d = 1'b0;
    end else if (frame_start_c) begin
      unr_d = 1'b1;
    end

    // A write in the consume cycle refills hold without counting as an overrun.
    if (in_if.i_valid) begin
      hold_d   = in_if.i_sample;
      hold_v_d = 1'b1;
      ovr_d    = hold_v_q && !consume_c;
    end

    // Left-align the outgoing word so bits past the sample width read as zero padding.
    frame_left_c = SLOT_BITS'(frame_d) << LEFT_SHIFT;

    if (fall_c) begin
      bit_idx_d = bit_idx_q + bit_idx_t'(1);
      lrck_d    = lrck_level(bit_idx_d);
      sdata_d   = slot_bit(frame_left_c, bit_idx_d[SLOT_IDX_W-1:0]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      bit_idx_q <= IDX_LAST;
      hold_q    <= '0;
      hold_v_q  <= 1'b0;
      frame_q   <= '0;
      lrck_q    <= 1'b0;
      sdata_q   <= 1'b0;
      ovr_q     <= 1'b0;
      unr_q     <= 1'b0;
    end else begin
      bit_idx_q <= bit_idx_d;
      hold_q    <= hold_d;
      hold_v_q  <= hold_v_d;
      frame_q   <= frame_d;
      lrck_q    <= lrck_d;
      sdata_q   <= sdata_d;
      ovr_q     <= ovr_d;
      unr_q     <= unr_d;
    end
  end

  assign o_lrck     = lrck_q;
  assign o_sdata    = sdata_q;
  assign o_overrun  = ovr_q;
  assign o_underrun = unr_q;

`ifdef I2S_TX_STATUS_CNT_EN
  localparam int unsigned STATUS_CNT_W = 16;

  logic [STATUS_CNT_W-1:0] ovr_cnt_q, ovr_cnt_d;
  logic [STATUS_CNT_W-1:0] unr_cnt_q, unr_cnt_d;

  // Saturating event counters, stepped alongside the pulse registers.
  always_comb begin
    ovr_cnt_d = ovr_cnt_q;
    unr_cnt_d = unr_cnt_q;
    if (ovr_d && (ovr_cnt_q != '1)) begin
      ovr_cnt_d = ovr_cnt_q + STATUS_CNT_W'(1);
    end
    if (unr_d && (unr_cnt_q != '1)) begin
      unr_cnt_d = unr_cnt_q + STATUS_CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ovr_cnt_q <= '0;
      unr_cnt_q <= '0;
    end else begin
      ovr_cnt_q <= ovr_cnt_d;
      unr_cnt_q <= unr_cnt_d;
    end
  end

  assign o_overrun_cnt  = ovr_cnt_q;
  assign o_underrun_cnt = unr_cnt_q;
`endif

endmodule

// File: tb/tb_i2s_tx.sv
// tb_i2s_tx: directed and random stimulus against a closed-form timing model of the I2S transmitter.
module tb_i2s_tx;

  localparam int FXP = 16;
  localparam int DIV = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  i2s_tx_if #(.fxp_size(FXP)) bus ();

  logic o_bclk, o_lrck, o_sdata, o_overrun, o_underrun;
`ifdef I2S_TX_STATUS_CNT_EN
  logic [15:0] o_overrun_cnt, o_underrun_cnt;
`endif

  i2s_tx #(
    .fxp_size (FXP),
    .bclk_div (DIV)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_if      (bus),
    .o_bclk     (o_bclk),
    .o_lrck     (o_lrck),
    .o_sdata    (o_sdata),
    .o_overrun  (o_overrun),
    .o_underrun (o_underrun)
`ifdef I2S_TX_STATUS_CNT_EN
    ,
    .o_overrun_cnt  (o_overrun_cnt),
    .o_underrun_cnt (o_underrun_cnt)
`endif
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference model: timing from edge count since reset, data from a held-sample rule.
  int                m_e = 0;
  logic              m_init = 1'b0;
  logic [FXP-1:0]    m_hold = '0;
  logic [FXP-1:0]    m_frame = '0;
  logic              m_hold_v = 1'b0;
  logic              exp_bclk = 1'b0, exp_lrck = 1'b0, exp_sdata = 1'b0;
  logic              exp_ovr = 1'b0, exp_unr = 1'b0;
  int                m_ocnt = 0, m_ucnt = 0;
  int                mf, midx, mk;

  initial forever begin
    @(posedge clk);
    if (!rst) begin
      m_init = 1'b1;
      m_e = 0; m_hold_v = 1'b0; m_frame = '0; m_hold = '0;
      exp_bclk = 1'b0; exp_lrck = 1'b0; exp_sdata = 1'b0; exp_ovr = 1'b0; exp_unr = 1'b0;
      m_ocnt = 0; m_ucnt = 0;
    end else if (m_init) begin
      m_e++;
      mf = m_e / (2 * DIV);
      exp_ovr = 1'b0;
      exp_unr = 1'b0;
      if ((m_e % (2 * DIV)) == 0 && (mf % 64) == 1) begin
        if (m_hold_v) begin
          m_frame  = m_hold;
          m_hold_v = 1'b0;
        end else begin
          exp_unr = 1'b1;
        end
      end
      if (bus.i_valid) begin
        exp_ovr  = m_hold_v;
        m_hold   = bus.i_sample;
        m_hold_v = 1'b1;
      end
      if (exp_ovr && m_ocnt < 65535) m_ocnt++;
      if (exp_unr && m_ucnt < 65535) m_ucnt++;
      exp_bclk = ((m_e / DIV) % 2) == 1;
      if (mf == 0) begin
        exp_lrck  = 1'b0;
        exp_sdata = 1'b0;
      end else begin
        midx      = (mf - 1) % 64;
        exp_lrck  = (midx >= 31) && (midx <= 62);
        mk        = midx % 32;
        exp_sdata = (mk < FXP) ? m_frame[FXP-1-mk] : 1'b0;
      end
    end
  end

  // Per-cycle comparison of all outputs against the model.
  initial forever begin
    @(negedge clk);
    if (m_init) begin
      chk("outs{bclk,lrck,sdata,ovr,unr}",
          64'({o_bclk, o_lrck, o_sdata, o_overrun, o_underrun}),
          64'({exp_bclk, exp_lrck, exp_sdata, exp_ovr, exp_unr}));
`ifdef I2S_TX_STATUS_CNT_EN
      chk("overrun_cnt", 64'(o_overrun_cnt), 64'(m_ocnt));
      chk("underrun_cnt", 64'(o_underrun_cnt), 64'(m_ucnt));
`endif
    end
  end

  // Edge counter since reset release and a recorder of codec-visible events.
  int r_e = 0;
  initial forever begin
    @(posedge clk);
    r_e <= rst ? r_e + 1 : 0;
  end

  int          rises, unr_tot, ovr_tot, first_ovr_e;
  int          last_unr_e, prev_unr_e, last_rise_e, prev_rise_e, lrck_rise_e, lrck_fall_e;
  logic [63:0] cap [4];
  logic        prev_bclk, prev_lrck;

  initial forever begin
    @(negedge clk);
    if (r_e == 0) begin
      rises = 0; unr_tot = 0; ovr_tot = 0; first_ovr_e = 0;
      last_unr_e = 0; prev_unr_e = 0; last_rise_e = 0; prev_rise_e = 0;
      lrck_rise_e = 0; lrck_fall_e = 0;
      for (int i = 0; i < 4; i++) cap[i] = '0;
      prev_bclk = 1'b0; prev_lrck = 1'b0;
    end else begin
      if (o_bclk && !prev_bclk) begin
        rises++;
        prev_rise_e = last_rise_e;
        last_rise_e = r_e;
        if (rises >= 2 && rises <= 257) cap[(rises - 2) / 64][63 - ((rises - 2) % 64)] = o_sdata;
      end
      if (o_lrck && !prev_lrck && lrck_rise_e == 0) lrck_rise_e = r_e;
      if (!o_lrck && prev_lrck && lrck_fall_e == 0) lrck_fall_e = r_e;
      if (o_underrun) begin
        unr_tot++;
        prev_unr_e = last_unr_e;
        last_unr_e = r_e;
      end
      if (o_overrun) begin
        ovr_tot++;
        if (first_ovr_e == 0) first_ovr_e = r_e;
      end
      prev_bclk = o_bclk;
      prev_lrck = o_lrck;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;
  endtask

  task automatic send(input logic [FXP-1:0] v);
    bus.i_sample = v;
    bus.i_valid  = 1'b1;
    step();
    bus.i_valid  = 1'b0;
  endtask

  task automatic wait_edges(input int n);
    for (int i = 0; i < 100000 && r_e < n; i++) step();
  endtask

  int rst_at;

  initial begin
    bus.i_valid  = 1'b0;
    bus.i_sample = '0;

    // Idle: clock geometry, word-select placement, underrun once per frame.
    do_reset();
    chk("reset_outs", 64'({o_bclk, o_lrck, o_sdata, o_overrun, o_underrun}), 64'(0));
    wait_edges(600);
    chk("idle_frame0", cap[0], 64'h0);
    chk("idle_frame1", cap[1], 64'h0);
    chk("idle_underruns", 64'(unr_tot), 64'(3));
    chk("bclk_period", 64'(last_rise_e - prev_rise_e), 64'(4));
    chk("frame_len", 64'(last_unr_e - prev_unr_e), 64'(256));
    chk("lrck_rise_edge", 64'(lrck_rise_e), 64'(128));
    chk("lrck_fall_edge", 64'(lrck_fall_e), 64'(256));
`ifdef I2S_TX_STATUS_CNT_EN
    chk("underrun_cnt_3", 64'(o_underrun_cnt), 64'(3));
`endif

    // Single sample, repeated in the following frame.
    do_reset();
    send(16'hA5C3);
    wait_edges(530);
    chk("a5c3_frame0", cap[0], 64'hA5C3_0000_A5C3_0000);
    chk("a5c3_frame1", cap[1], 64'hA5C3_0000_A5C3_0000);
    chk("a5c3_underruns", 64'(unr_tot), 64'(2));
    chk("a5c3_overruns", 64'(ovr_tot), 64'(0));

    // Two writes before one frame start: newest wins, overrun on the second.
    do_reset();
    send(16'h1234);
    step();
    send(16'h8001);
    wait_edges(300);
    chk("ovr_frame0", cap[0], 64'h8001_0000_8001_0000);
    chk("ovr_count", 64'(ovr_tot), 64'(1));
    chk("ovr_edge", 64'(first_ovr_e), 64'(3));
    chk("ovr_underruns", 64'(unr_tot), 64'(1));

    // Write on the frame-start clock with hold full.
    do_reset();
    send(16'h1111);
    step();
    step();
    send(16'h2222);
    wait_edges(515);
    chk("coinc_frame0", cap[0], 64'h1111_0000_1111_0000);
    chk("coinc_frame1", cap[1], 64'h2222_0000_2222_0000);
    chk("coinc_overruns", 64'(ovr_tot), 64'(0));
    chk("coinc_underruns", 64'(unr_tot), 64'(0));

    // Reset in the middle of a frame.
    do_reset();
    wait_edges(86);
    chk("pre_rst_bclk", 64'(o_bclk), 64'(1));
    rst = 1'b0;
    step();
    chk("mid_rst_outs", 64'({o_bclk, o_lrck, o_sdata, o_overrun, o_underrun}), 64'(0));
    rst = 1'b1;
    wait_edges(3);
    chk("post_rst_e3", 64'({o_bclk, o_underrun}), 64'(2'b10));
    step();
    chk("post_rst_first_fall", 64'({o_bclk, o_underrun}), 64'(2'b01));

    // Random traffic near the frame rate with one asynchronous-in-time reset.
    do_reset();
    rst_at = 3000 + int'($urandom_range(0, 500));
    for (int i = 0; i < 8000; i++) begin
      if (i == rst_at)     rst = 1'b0;
      if (i == rst_at + 2) rst = 1'b1;
      bus.i_valid  = ($urandom_range(0, 199) == 0);
      bus.i_sample = FXP'($urandom);
      step();
    end
    bus.i_valid = 1'b0;
    step();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
